pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//   Drives and supervises the video PLL: pulses the PLL reset input and watches
//   the PLL lock output. It qualifies lock over a stable window and then releases
//   the composite-video pipeline reset. On lock loss it re-resets the PLL. After
//   repeated lock timeouts it stops and reports a fault.
//   Clocked by the board reference clock, the same clock that feeds the PLL.
// PARAMETERS
//   SYNC_STAGES       2        synchronizer flops on pll_lock (>=2)
//   PLL_RESET_CYCLES  16       cycles pll_reset is held high per attempt (>=1)
//   LOCK_TIMEOUT      1048576  cycles allowed in WAIT_LOCK before a retry (>=2)
//   STABLE_CYCLES     4096     consecutive locked cycles required before RUN (>=1)
//   MAX_RETRIES       4        lock timeouts tolerated before FAULT (>=1)
// PORTS
//   clk          in   1  reference clock (same net as PLL refclk)
//   reset        in   1  asynchronous, active-high; all state cleared
//   pll_lock     in   1  PLL lock, asynchronous to clk
//   pll_reset    out  1  to PLL reset input, active-high
//   video_reset  out  1  active-high reset for the video pipeline
//   locked_ok    out  1  high only in RUN
//   fault        out  1  high only in FAULT
//   loss_count   out  8  lock-loss events seen in RUN, saturates at 255
//   state_dbg    out  3  encoded state: PLL_RST=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAULT=4
// BEHAVIOUR
//   Reset: one clock, async active-high reset, applied to all flops.
//   - Reset values: state=PLL_RST, pll_reset=1, video_reset=1, locked_ok=0,
//     fault=0, loss_count=0, counters=0, retries=0.
//   - A reset mid-operation returns to these values immediately (async) from any state.
//   Sync: pll_lock passes through SYNC_STAGES flops (reset to 0) to give lock_s.
//     No other path uses pll_lock.
//   Outputs: all registered, decoded from the registered state.
//   - pll_reset   = (state==PLL_RST) || (state==FAULT)
//   - video_reset = (state != RUN)
//   State machine:
//   - PLL_RST: stays exactly PLL_RESET_CYCLES cycles (cnt 0..N-1), then goes to
//     WAIT_LOCK with cnt=0.
//   - WAIT_LOCK:
//     * lock_s=1 -> STABLE, cnt=0.
//     * else cnt reaching LOCK_TIMEOUT-1 counts a timeout: retries+1.
//       If the new retries==MAX_RETRIES -> FAULT; else -> PLL_RST.
//     * lock_s rising on the timeout cycle: the lock wins, go to STABLE.
//   - STABLE:
//     * lock_s=0 -> WAIT_LOCK with cnt=0 (timeout window restarts, retries kept).
//     * lock_s=1 for STABLE_CYCLES consecutive cycles -> RUN, retries=0.
//   - RUN: lock_s=0 -> PLL_RST, loss_count+1 (saturating at 255).
//   - FAULT: terminal. Leaves only by asserting reset.
//   Latency:
//   - pll_lock falling in RUN raises video_reset and pll_reset
//     SYNC_STAGES+1 clk edges later.
//   - After lock_s rises: video_reset falls STABLE_CYCLES+1 edges later.
//   - Sub-window lock glitches never deassert video_reset.
//   Widths: cnt is $clog2(max(PLL_RESET_CYCLES,LOCK_TIMEOUT,STABLE_CYCLES))+1 bits.
//     retries is $clog2(MAX_RETRIES+1) bits. Compares are unsigned, no wrap.
// TESTING (SYNC_STAGES=2 PLL_RESET_CYCLES=4 LOCK_TIMEOUT=32 STABLE_CYCLES=8 MAX_RETRIES=2)
//   1. Release reset, pll_lock=1 from cycle 0 -> pll_reset high exactly 4 cycles;
//      RUN and video_reset=0 a fixed, checked cycle count later; locked_ok=1.
//   2. In RUN, drop pll_lock -> video_reset=1 and pll_reset=1 after 3 edges;
//      loss_count 0->1; relock returns to RUN.
//   3. 5-cycle lock pulse inside STABLE -> back to WAIT_LOCK; video_reset never
//      drops; full 8-cycle lock then reaches RUN.
//   4. pll_lock held 0 -> two 32-cycle timeouts, each preceded by a 4-cycle
//      pll_reset; then FAULT, fault=1, pll_reset=1, stuck until reset.
//   5. Force 300 RUN lock losses -> loss_count saturates at 255, no wrap.
//   6. Assert reset in STABLE and again in RUN -> all outputs at reset values
//      the same cycle, before any clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Supervises the video PLL: pulses its reset, qualifies lock, releases the video pipeline reset.
// Latency: lock loss in RUN reaches pll_reset/video_reset SYNC_STAGES+1 edges after pll_lock falls.
// Backpressure: none; a free-running supervisor, all outputs registered every cycle.
//
// Ports:
//   clk          reference clock (same net as the PLL refclk)
//   reset        asynchronous, active-high; clears all state
//   pll_lock     PLL lock indication, asynchronous to clk
//   pll_reset    active-high reset to the PLL (PLL_RST and FAULT)
//   video_reset  active-high reset to the video pipeline (all states but RUN)
//   locked_ok    high only in RUN
//   fault        high only in FAULT
//   loss_count   lock-loss events seen in RUN, saturating at 255
//   state_dbg    encoded state: PLL_RST=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAULT=4
module pll_lock_supervisor #(
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 1048576,
  parameter int STABLE_CYCLES    = 4096,
  parameter int MAX_RETRIES      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       video_reset,
  output logic       locked_ok,
  output logic       fault,
  output logic [7:0] loss_count,
  output logic [2:0] state_dbg
);

  localparam int MAX_AB = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // pll_lock is asynchronous: only the last synchronizer stage is ever used.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retries_q, retries_d;
  logic [7:0]      loss_q, loss_d;
  logic            pll_reset_q, video_reset_q, locked_ok_q, fault_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    loss_d    = loss_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          retries_d = retries_q + RW'(1);
          cnt_d     = '0;
          state_d   = (retries_d == RETRY_MAX) ? FAULT : PLL_RST;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        // A dropout restarts the timeout window but keeps the retry tally.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered alongside the state, decoded from its next value,
  // so they always match the registered state with no combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      retries_q     <= '0;
      loss_q        <= '0;
      pll_reset_q   <= 1'b1;
      video_reset_q <= 1'b1;
      locked_ok_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retries_q     <= retries_d;
      loss_q        <= loss_d;
      pll_reset_q   <= (state_d == PLL_RST) || (state_d == FAULT);
      video_reset_q <= (state_d != RUN);
      locked_ok_q   <= (state_d == RUN);
      fault_q       <= (state_d == FAULT);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign video_reset = video_reset_q;
  assign locked_ok   = locked_ok_q;
  assign fault       = fault_q;
  assign loss_count  = loss_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: scripted and random pll_lock waveforms, scoreboard-checked.
// Latency: expected outputs are queued per cycle and compared half a cycle after each edge.
// Backpressure: none; the monitor pops one expected entry per clock while enabled.
module tb_pll_lock_supervisor;

  localparam int SS   = 2;
  localparam int PRC  = 4;
  localparam int TO   = 32;
  localparam int SC   = 8;
  localparam int MR   = 2;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset, video_reset, locked_ok, fault;
  logic [7:0] loss_count;
  logic [2:0] state_dbg;

  pll_lock_supervisor #(
    .SYNC_STAGES(SS), .PLL_RESET_CYCLES(PRC), .LOCK_TIMEOUT(TO),
    .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .video_reset(video_reset), .locked_ok(locked_ok),
    .fault(fault), .loss_count(loss_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       vrst;
    logic       lok;
    logic       flt;
    logic [7:0] loss;
  } exp_t;

  typedef struct {
    int   idx;
    exp_t v;
  } sb_t;

  bit    lock_in [MAXC];
  exp_t  exp_arr [MAXC];
  sb_t   sb_q [$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  string cur_name = "none";

  // Lock value seen by the supervisor at edge e: pll_lock delayed by the synchronizer.
  function automatic bit lk(int e);
    int i;
    i = e - SS - 1;
    if (i < 0 || i >= MAXC) return 1'b0;
    return lock_in[i];
  endfunction

  function automatic exp_t mk(int st, int loss);
    exp_t x;
    x.st   = 3'(st);
    x.prst = (st == 0) || (st == 4);
    x.vrst = (st != 3);
    x.lok  = (st == 3);
    x.flt  = (st == 4);
    x.loss = 8'(loss);
    return x;
  endfunction

  // Segment model: each state lasts until the first edge where its exit rule holds.
  // States: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT.
  function automatic void model(int len);
    int  t, st, loss, retries, e, nxt, k;
    bit  found;
    t = 0; st = 0; loss = 0; retries = 0;
    while (t <= len) begin
      e = len + 1; nxt = st; found = 1'b0;
      case (st)
        0: begin e = t + PRC; nxt = 1; end
        1: begin
          k = t + 1;
          while (!found && k <= t + TO) begin
            if (lk(k)) found = 1'b1; else k++;
          end
          if (found) begin e = k; nxt = 2; end
          else begin
            e = t + TO; retries++;
            nxt = (retries == MR) ? 4 : 0;
          end
        end
        2: begin
          k = t + 1;
          while (!found && k <= t + SC) begin
            if (!lk(k)) found = 1'b1; else k++;
          end
          if (found) begin e = k; nxt = 1; end
          else begin e = t + SC; nxt = 3; retries = 0; end
        end
        3: begin
          k = t + 1;
          while (!found && k <= len) begin
            if (!lk(k)) found = 1'b1; else k++;
          end
          if (found) begin e = k; nxt = 0; end
        end
        default: begin e = len + 1; nxt = 4; end
      endcase
      for (int j = t; j <= len && j < e; j++) exp_arr[j] = mk(st, loss);
      if (st == 3 && e <= len) loss = (loss < 255) ? loss + 1 : 255;
      st = nxt;
      t  = e;
    end
  endfunction

  initial begin
    sb_t  s;
    exp_t got;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && sb_q.size() > 0) begin
        s   = sb_q.pop_front();
        got = {state_dbg, pll_reset, video_reset, locked_ok, fault, loss_count};
        n_vec++;
        if (got !== s.v) begin
          n_err++;
          $display("FAIL %s cyc %0d: got st=%0d prst=%b vrst=%b lok=%b flt=%b loss=%0d, want st=%0d prst=%b vrst=%b lok=%b flt=%b loss=%0d",
                   cur_name, s.idx, got.st, got.prst, got.vrst, got.lok, got.flt, got.loss,
                   s.v.st, s.v.prst, s.v.vrst, s.v.lok, s.v.flt, s.v.loss);
        end
      end
    end
  end

  task automatic fill(int lo, int hi, bit v);
    for (int c = lo; c <= hi; c++) lock_in[c] = v;
  endtask

  // Reset, then release and play lock_in[0..len]; optionally reassert reset
  // mid-cycle at the end and check outputs before the next clock edge.
  task automatic run_scn(int len, bit rst_chk, string name);
    exp_t got;
    cur_name = name;
    model(len);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b0;
      pll_lock = lock_in[c];
      sb_q.push_back('{c, exp_arr[c]});
      mon_en = 1'b1;
    end
    #3;
    if (rst_chk) begin
      reset = 1'b1;
      #1;
      got = {state_dbg, pll_reset, video_reset, locked_ok, fault, loss_count};
      n_vec++;
      if (got !== mk(0, 0)) begin
        n_err++;
        $display("FAIL %s async_reset: got st=%0d prst=%b vrst=%b lok=%b flt=%b loss=%0d, want st=0 prst=1 vrst=1 lok=0 flt=0 loss=0",
                 name, got.st, got.prst, got.vrst, got.lok, got.flt, got.loss);
      end
    end
    mon_en = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    int c, n;
    bit v;

    // Clean lock from the start, a 5-cycle dropout in RUN, relock; reset in RUN.
    fill(0, MAXC - 1, 1'b0);
    fill(0, 29, 1'b1);
    fill(35, 80, 1'b1);
    run_scn(80, 1'b1, "lock_loss_relock");

    // Short lock pulse inside STABLE, then a full window reaching RUN.
    fill(0, MAXC - 1, 1'b0);
    fill(2, 6, 1'b1);
    fill(10, 40, 1'b1);
    run_scn(40, 1'b0, "stable_glitch");

    // Reset asserted while in STABLE.
    fill(0, MAXC - 1, 1'b1);
    run_scn(8, 1'b1, "reset_in_stable");

    // No lock at all: two timeouts then terminal FAULT.
    fill(0, MAXC - 1, 1'b0);
    run_scn(120, 1'b0, "timeout_fault");

    // 300 single-cycle dropouts in RUN: loss_count saturates at 255.
    fill(0, MAXC - 1, 1'b1);
    for (int i = 0; i < 300; i++) lock_in[15 + 20 * i] = 1'b0;
    run_scn(6020, 1'b0, "loss_saturate");

    // Random lock waveforms mixing short glitches and long runs.
    for (int r = 0; r < 8; r++) begin
      c = 0;
      v = ($urandom_range(0, 1) == 1);
      while (c < 300) begin
        if ($urandom_range(0, 3) == 0) n = $urandom_range(1, 6);
        else n = $urandom_range(8, 40);
        for (int k = 0; k < n && c < 300; k++) begin
          lock_in[c] = v;
          c++;
        end
        v = !v;
      end
      run_scn(299, (r % 2) == 1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
